// File: rtl/isa_int_pkg.sv
// Shared integer-ISA definitions: opcode encodings, datapath widths and the
// tag+data result record carried on the common data bus.
package isa_int_pkg;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } result_t;

endpackage

// File: rtl/issueint_alu_if.sv
// Issue-queue handshake plus CDB broadcast/arbitration signals of the integer
// execute unit. master = queue/arbiter side, slave = execute unit.
interface issueint_alu_if;
   import isa_int_pkg::*;

   logic [3:0]        issueint_opcode;
   logic [TAG_W-1:0]  issueint_rdtag;
   logic [DATA_W-1:0] issueint_rsdata;
   logic [DATA_W-1:0] issueint_rtdata;
   logic              issueint_ready;
   logic              issueint_done;
   logic              cdb_req;
   logic              cdb_grant;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              cdb_valid;

   modport master (
      output issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata,
      output issueint_ready, cdb_grant,
      input  issueint_done, cdb_req, cdb_tag, cdb_data, cdb_valid
   );

   modport slave (
      input  issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata,
      input  issueint_ready, cdb_grant,
      output issueint_done, cdb_req, cdb_tag, cdb_data, cdb_valid
   );

endinterface

// File: rtl/int_alu.sv
// Combinational integer ALU: opcode/rs/rt to result. Reserved opcodes give 0.
// Shift amounts come from rs[4:0]; the shifted operand is rt.
module int_alu
   import isa_int_pkg::*;
(
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic [DATA_W-1:0] result
);

   logic [4:0] shamt;
   assign shamt = rs[4:0];

   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = rs + rt;
         OP_SUB:  result = rs - rt;
         OP_AND:  result = rs & rt;
         OP_OR:   result = rs | rt;
         OP_XOR:  result = rs ^ rt;
         OP_NOR:  result = ~(rs | rt);
         OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(rs) < $signed(rt))};
         OP_SLTU: result = {{(DATA_W-1){1'b0}}, (rs < rt)};
         OP_SLL:  result = rt << shamt;
         OP_SRL:  result = rt >> shamt;
         OP_SRA:  result = $signed(rt) >>> shamt;
         OP_LUI:  result = {rt[15:0], 16'h0};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/issueint_alu.sv
// Integer issue/execute unit: credit-gated pop from the issue queue, fixed-latency
// ALU pipeline, in-order result FIFO onto the CDB. Optional ISSUEINT_BYPASS_EN.
module issueint_alu
   import isa_int_pkg::*;
#(
   parameter int LATENCY    = 1,
   parameter int OBUF_DEPTH = 2
) (
   input logic           clk,
   input logic           reset,
   issueint_alu_if.slave bus
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OBUF_DEPTH);

   logic              accept, done, cdb_req, cdb_pop;
   logic              buf_wr, buf_rd, buf_nempty, byp_avail;
   logic [CNT_W-1:0]  inflight, buf_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   result_t           buf_mem [OBUF_DEPTH];
   result_t           alu_res, last_res, cdb_res, hold_res;
   logic              s1_vld, last_vld;
   logic [3:0]        s1_op;
   logic [TAG_W-1:0]  s1_tag;
   logic [DATA_W-1:0] s1_rs, s1_rt, alu_out;

   // Credits cover pipeline plus buffer, so a pop in this cycle frees a slot now.
   assign done   = bus.issueint_ready && ((inflight < DEPTH_C) || cdb_pop);
   assign accept = bus.issueint_ready && done;

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= '0;
      end else begin
         case ({accept, cdb_pop})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) s1_vld <= 1'b0;
      else       s1_vld <= accept;
      if (accept) begin
         s1_op  <= bus.issueint_opcode;
         s1_tag <= bus.issueint_rdtag;
         s1_rs  <= bus.issueint_rsdata;
         s1_rt  <= bus.issueint_rtdata;
      end
   end

   int_alu u_alu (
      .opcode (s1_op),
      .rs     (s1_rs),
      .rt     (s1_rt),
      .result (alu_out)
   );

   assign alu_res = {s1_tag, alu_out};

   if (LATENCY == 1) begin : g_lat1
      assign last_vld = s1_vld;
      assign last_res = alu_res;
   end else begin : g_latn
      result_t            dly     [LATENCY-1];
      logic [LATENCY-2:0] dly_vld;

      always_ff @(posedge clk) begin
         if (reset) begin
            dly_vld <= '0;
         end else begin
            for (int i = LATENCY-2; i > 0; i--) dly_vld[i] <= dly_vld[i-1];
            dly_vld[0] <= s1_vld;
         end
         for (int i = LATENCY-2; i > 0; i--) dly[i] <= dly[i-1];
         dly[0] <= alu_res;
      end

      assign last_vld = dly_vld[LATENCY-2];
      assign last_res = dly[LATENCY-2];
   end

   assign buf_nempty = (buf_cnt != '0);

`ifdef ISSUEINT_BYPASS_EN
   assign byp_avail = !buf_nempty && last_vld;
`else
   assign byp_avail = 1'b0;
`endif

   assign cdb_req = buf_nempty || byp_avail;
   assign cdb_pop = cdb_req && bus.cdb_grant;
   assign buf_rd  = cdb_pop && buf_nempty;
   assign buf_wr  = last_vld && !(byp_avail && bus.cdb_grant);

   always_comb begin
      cdb_res = hold_res;
      if (buf_nempty)     cdb_res = buf_mem[rd_ptr];
      else if (byp_avail) cdb_res = last_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         buf_cnt  <= '0;
         hold_res <= '0;
      end else begin
         if (buf_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (buf_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         buf_cnt  <= buf_cnt + CNT_W'(buf_wr) - CNT_W'(buf_rd);
         hold_res <= cdb_res;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_wr) buf_mem[wr_ptr] <= last_res;
   end

   assign bus.issueint_done = done;
   assign bus.cdb_req       = cdb_req;
   assign bus.cdb_valid     = cdb_pop;
   assign bus.cdb_tag       = cdb_res.tag;
   assign bus.cdb_data      = cdb_res.data;

endmodule
